// File: rtl/rf_writeback.sv
// rtl/rf_writeback.sv - ALU/load writeback arbiter and FIFO feeding the register file write port
module rf_writeback #(
    parameter int width = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_addr,
    input  logic [width-1:0]           alu_data,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [4:0]                 ld_addr,
    input  logic [width-1:0]           ld_data,
    input  logic                       wb_hold,
    output logic [width-1:0]           write_data,
    output logic [4:0]                 write_addr,
    output logic                       rf_en,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [4:0]       addr_mem [DEPTH];
    logic [width-1:0] data_mem [DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    // 1 = ALU wins the next contested cycle; flips after every contested accept
    logic             prefer_alu;

    logic             not_full;
    logic             alu_grant;
    logic             ld_grant;
    logic             alu_acc;
    logic             ld_acc;
    logic             contested;
    logic [4:0]       acc_addr;
    logic [width-1:0] acc_data;
    logic             push;
    logic             pop;

    // Grant and handshake decode; readys depend only on state and valids, never on payload
    always_comb begin
        not_full  = (count < CW'(DEPTH));
        alu_grant = !ld_valid || (alu_valid && prefer_alu);
        ld_grant  = !alu_valid || (ld_valid && !prefer_alu);
        alu_ready = not_full && alu_grant;
        ld_ready  = not_full && ld_grant;
        alu_acc   = alu_valid && alu_ready;
        ld_acc    = ld_valid && ld_ready;
        contested = alu_valid && ld_valid && not_full;
        acc_addr  = alu_acc ? alu_addr : ld_addr;
        acc_data  = alu_acc ? alu_data : ld_data;
        // x0 writes complete the handshake but are never buffered
        push      = (alu_acc || ld_acc) && (acc_addr != 5'd0);
        pop       = !wb_hold && (count != '0);
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= acc_addr;
            data_mem[wr_ptr] <= acc_data;
        end
    end

    // Pointers, occupancy, round-robin state and the registered write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            prefer_alu <= 1'b1;
            rf_en      <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PW'(1);
                rf_en      <= 1'b1;
                write_addr <= addr_mem[rd_ptr];
                write_data <= data_mem[rd_ptr];
            end else begin
                rf_en      <= 1'b0;
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (contested) begin
                prefer_alu <= !prefer_alu;
            end
        end
    end

    assign fifo_count = count;

endmodule

// File: tb/tb_rf_writeback.sv
// tb/tb_rf_writeback.sv - self-checking bench for rf_writeback with scoreboard and register file model
module tb_rf_writeback;

    localparam int W = 32;
    localparam int D = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [4:0]    alu_addr = '0;
    logic [W-1:0]  alu_data = '0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [4:0]    ld_addr = '0;
    logic [W-1:0]  ld_data = '0;
    logic          wb_hold = 1'b0;
    logic [W-1:0]  write_data;
    logic [4:0]    write_addr;
    logic          rf_en;
    logic [$clog2(D+1)-1:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int accepts = 0;

    logic [36:0]   sb [$];
    logic [36:0]   exp_e;
    logic [W-1:0]  bench_rf [32];
    logic [W-1:0]  gold_rf [32];
    logic          alu_acc_q = 1'b0;
    logic          ld_acc_q = 1'b0;

    rf_writeback #(.width(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .wb_hold    (wb_hold),
        .write_data (write_data),
        .write_addr (write_addr),
        .rf_en      (rf_en),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Monitor: retire writes against the scoreboard, record accepts about to happen at the next edge
    always @(negedge clk) begin
        alu_acc_q = 1'b0;
        ld_acc_q  = 1'b0;
        if (rst) begin
            if (rf_en) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_write: got addr=%0d data=%h, required no write", write_addr, write_data);
                end else begin
                    exp_e = sb.pop_front();
                    if ({write_addr, write_data} !== exp_e) begin
                        errors++;
                        $display("FAIL sb_order: got addr=%0d data=%h, required addr=%0d data=%h",
                                 write_addr, write_data, exp_e[36:32], exp_e[31:0]);
                    end
                end
                bench_rf[write_addr] = write_data;
            end
            if (alu_valid && alu_ready) begin
                alu_acc_q = 1'b1;
                accepts++;
                if (alu_addr != 5'd0) begin
                    sb.push_back({alu_addr, alu_data});
                    gold_rf[alu_addr] = alu_data;
                end
            end
            if (ld_valid && ld_ready) begin
                ld_acc_q = 1'b1;
                accepts++;
                if (ld_addr != 5'd0) begin
                    sb.push_back({ld_addr, ld_data});
                    gold_rf[ld_addr] = ld_data;
                end
            end
            checks++;
            if (alu_acc_q && ld_acc_q) begin
                errors++;
                $display("FAIL one_accept: got both sources accepted, required at most one");
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL reset_rf_en: got %b, required 0", rf_en); end
        checks++; if (write_addr !== 5'd0) begin errors++; $display("FAIL reset_write_addr: got %0d, required 0", write_addr); end
        checks++; if (write_data !== 32'd0) begin errors++; $display("FAIL reset_write_data: got %h, required 0", write_data); end
        checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d, required 0", fifo_count); end
        rst = 1'b1;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready: got %b, required 1", alu_ready); end
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready: got %b, required 1", ld_ready); end
    endtask

    task automatic test_single();
        alu_addr = 5'd5; alu_data = 32'hDEADBEEF; alu_valid = 1'b1;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b, required 1", alu_ready); end
        step();
        alu_valid = 1'b0;
        checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got rf_en=%b, required 0", rf_en); end
        step();
        checks++; if ({rf_en, write_addr, write_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            errors++; $display("FAIL single_write: got en=%b addr=%0d data=%h, required en=1 addr=5 data=deadbeef", rf_en, write_addr, write_data);
        end
        step();
        checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL single_one_pulse: got rf_en=%b, required 0", rf_en); end
        checks++; if (bench_rf[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rf_x5: got %h, required deadbeef", bench_rf[5]); end
    endtask

    task automatic test_contention();
        alu_addr = 5'd3; alu_data = 32'h11; alu_valid = 1'b1;
        ld_addr = 5'd4; ld_data = 32'h22; ld_valid = 1'b1;
        #1;
        checks++; if ({alu_ready, ld_ready} !== 2'b10) begin errors++; $display("FAIL contend1_grant: got alu=%b ld=%b, required alu=1 ld=0", alu_ready, ld_ready); end
        step();
        alu_valid = 1'b0;
        #1;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL contend1_ld_ready: got %b, required 1", ld_ready); end
        step();
        ld_valid = 1'b0;
        checks++; if ({rf_en, write_addr, write_data} !== {1'b1, 5'd3, 32'h11}) begin
            errors++; $display("FAIL contend1_x3: got en=%b addr=%0d data=%h, required en=1 addr=3 data=11", rf_en, write_addr, write_data);
        end
        step();
        checks++; if ({rf_en, write_addr, write_data} !== {1'b1, 5'd4, 32'h22}) begin
            errors++; $display("FAIL contend1_x4: got en=%b addr=%0d data=%h, required en=1 addr=4 data=22", rf_en, write_addr, write_data);
        end
        step();
        alu_addr = 5'd3; alu_data = 32'h33; alu_valid = 1'b1;
        ld_addr = 5'd4; ld_data = 32'h44; ld_valid = 1'b1;
        #1;
        checks++; if ({alu_ready, ld_ready} !== 2'b01) begin errors++; $display("FAIL contend2_grant: got alu=%b ld=%b, required alu=0 ld=1", alu_ready, ld_ready); end
        step();
        ld_valid = 1'b0;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL contend2_alu_ready: got %b, required 1", alu_ready); end
        step();
        alu_valid = 1'b0;
        checks++; if ({rf_en, write_addr, write_data} !== {1'b1, 5'd4, 32'h44}) begin
            errors++; $display("FAIL contend2_x4: got en=%b addr=%0d data=%h, required en=1 addr=4 data=44", rf_en, write_addr, write_data);
        end
        step();
        checks++; if ({rf_en, write_addr, write_data} !== {1'b1, 5'd3, 32'h33}) begin
            errors++; $display("FAIL contend2_x3: got en=%b addr=%0d data=%h, required en=1 addr=3 data=33", rf_en, write_addr, write_data);
        end
        step();
    endtask

    task automatic test_x0();
        alu_addr = 5'd0; alu_data = 32'h1234; alu_valid = 1'b1;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b, required 1", alu_ready); end
        step();
        alu_valid = 1'b0;
        checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL x0_count: got %0d, required 0", fifo_count); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL x0_no_write: got rf_en=%b cycle %0d, required 0", rf_en, i); end
        end
    endtask

    task automatic test_hold();
        wb_hold = 1'b1;
        alu_addr = 5'd7; alu_data = 32'hA; alu_valid = 1'b1;
        step();
        alu_addr = 5'd8; alu_data = 32'hB;
        step();
        alu_valid = 1'b0;
        #1;
        checks++; if (fifo_count !== 2'd2) begin errors++; $display("FAIL hold_count: got %0d, required 2", fifo_count); end
        checks++; if ({alu_ready, ld_ready} !== 2'b00) begin errors++; $display("FAIL hold_full_ready: got alu=%b ld=%b, required 0 0", alu_ready, ld_ready); end
        checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL hold_no_write: got rf_en=%b, required 0", rf_en); end
        wb_hold = 1'b0;
        step();
        checks++; if ({rf_en, write_addr, write_data, fifo_count} !== {1'b1, 5'd7, 32'hA, 2'd1}) begin
            errors++; $display("FAIL hold_drain_x7: got en=%b addr=%0d data=%h cnt=%0d, required 1 7 a 1", rf_en, write_addr, write_data, fifo_count);
        end
        step();
        checks++; if ({rf_en, write_addr, write_data, fifo_count} !== {1'b1, 5'd8, 32'hB, 2'd0}) begin
            errors++; $display("FAIL hold_drain_x8: got en=%b addr=%0d data=%h cnt=%0d, required 1 8 b 0", rf_en, write_addr, write_data, fifo_count);
        end
        step();
        checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL hold_drain_end: got rf_en=%b, required 0", rf_en); end
    endtask

    task automatic test_reset_mid();
        wb_hold = 1'b1;
        alu_addr = 5'd9; alu_data = 32'hC; alu_valid = 1'b1;
        step();
        alu_addr = 5'd10; alu_data = 32'hD;
        step();
        alu_valid = 1'b0;
        checks++; if (fifo_count !== 2'd2) begin errors++; $display("FAIL rmid_count_before: got %0d, required 2", fifo_count); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if ({rf_en, write_addr, write_data, fifo_count} !== {1'b0, 5'd0, 32'd0, 2'd0}) begin
            errors++; $display("FAIL rmid_async_clear: got en=%b addr=%0d data=%h cnt=%0d, required all 0", rf_en, write_addr, write_data, fifo_count);
        end
        sb.delete();
        for (int r = 0; r < 32; r++) gold_rf[r] = bench_rf[r];
        step();
        rst = 1'b1;
        wb_hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL rmid_no_write: got rf_en=%b cycle %0d, required 0", rf_en, i); end
        end
    endtask

    task automatic test_random();
        int start;
        int cyc;
        int w;
        start = accepts;
        cyc = 0;
        while ((accepts - start) < 1000 && cyc < 20000) begin
            if (!alu_valid || alu_acc_q) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_addr  = 5'($urandom);
                alu_data  = $urandom;
            end
            if (!ld_valid || ld_acc_q) begin
                ld_valid = 1'($urandom_range(0, 1));
                ld_addr  = 5'($urandom);
                ld_data  = $urandom;
            end
            wb_hold = ($urandom_range(0, 3) == 0);
            step();
            cyc++;
        end
        checks++; if (cyc >= 20000) begin errors++; $display("FAIL rand_accept_timeout: got %0d accepts, required 1000", accepts - start); end
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        wb_hold   = 1'b0;
        w = 0;
        while (fifo_count != 0 && w < 100) begin
            step();
            w++;
        end
        checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL rand_drain_timeout: got count=%0d, required 0", fifo_count); end
        step();
        step();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rand_sb_leftover: got %0d pending, required 0", sb.size()); end
        for (int r = 1; r < 32; r++) begin
            checks++;
            if (bench_rf[r] !== gold_rf[r]) begin
                errors++; $display("FAIL rand_rf_x%0d: got %h, required %h", r, bench_rf[r], gold_rf[r]);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            bench_rf[r] = '0;
            gold_rf[r]  = '0;
        end
        test_reset();
        test_single();
        test_contention();
        test_x0();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
